pixel_stream_source: RTL
========================

// Module: pixel_stream_source
// PURPOSE
//  Raster pixel transmitter feeding the 5x5 separable gaussian stage (drives its i_pixel/i_pixel_valid).
//  Emits frames of IMAGE_WIDTH x IMAGE_HEIGHT pixels with programmable horizontal and vertical blanking.
//  Supports selectable test patterns, valid/ready backpressure and frame markers, so filter line buffers,
//  start-up counters and row counters can be exercised on hardware and in simulation.
// PARAMETERS
//  DATA_WIDTH    8    pixel width
//  IMAGE_WIDTH   640  active pixels per line (>=2)
//  IMAGE_HEIGHT  480  active lines per frame (>=2)
//  H_BLANK       16   idle cycles after each line (>=1)
//  V_BLANK       4    idle cycles after last line of frame, in addition to that line's H_BLANK (>=1)
// PORTS
//  clk            in   1                 clock
//  rst_n          in   1                 async active-low reset
//  i_enable       in   1                 start/continue frames
//  i_pattern      in   2                 0 ramp, 1 column gradient, 2 8x8 checker, 3 constant
//  i_const        in   DATA_WIDTH        value for pattern 3
//  i_ready        in   1                 downstream accepts pixel this cycle
//  o_pixel        out  DATA_WIDTH        pixel data
//  o_pixel_valid  out  1                 o_pixel valid
//  o_sof          out  1                 with valid: first pixel of frame
//  o_eol          out  1                 with valid: last pixel of line
//  o_eof          out  1                 with valid: last pixel of frame
//  o_col          out  clog2(IMAGE_WIDTH)   column of o_pixel
//  o_row          out  clog2(IMAGE_HEIGHT)  row of o_pixel
//  o_busy         out  1                 high in any state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0; reset mid-frame aborts immediately, no partial flush.
//  - FSM: IDLE -> ACTIVE when i_enable=1 (first valid pixel registered next cycle, o_sof=1).
//    ACTIVE -> HBLANK after last-column pixel accepted; HBLANK -> ACTIVE after H_BLANK cycles,
//    or -> VBLANK if that line was row IMAGE_HEIGHT-1; VBLANK -> ACTIVE (new frame) after V_BLANK
//    cycles if i_enable=1, else -> IDLE.
//  - i_enable deasserted mid-frame: current frame completes in full; then IDLE.
//  - Handshake: transfer when o_pixel_valid && i_ready. While valid && !i_ready: o_pixel, markers,
//    o_col, o_row held stable, counters frozen. o_pixel_valid never drops in ACTIVE without a transfer.
//  - Blanking counters run every cycle regardless of i_ready; o_pixel_valid=0 and o_pixel=0 in blanking.
//  - i_pattern and i_const sampled only at frame start (IDLE/VBLANK -> ACTIVE); held for whole frame.
//  - Patterns (all mod 2^DATA_WIDTH, truncate, no saturation):
//    0 ramp: pixel index within frame starting 1 (row*IMAGE_WIDTH+col+1); 0 wraps after 255.
//    1 gradient: col. 2 checker: {DATA_WIDTH{col[3]^row[3]}}. 3 constant: i_const.
//  - All outputs registered; o_col/o_row describe the pixel currently presented.
//  - Markers: o_sof at (0,0); o_eol at col=IMAGE_WIDTH-1; o_eof at last pixel (o_eol also 1).
//  - Back-to-back frames: exactly H_BLANK+V_BLANK idle cycles between o_eof transfer and next o_sof.
// TESTING (use IMAGE_WIDTH=8, IMAGE_HEIGHT=4, H_BLANK=2, V_BLANK=3)
//  1 Reset then i_enable=1, i_ready=1, pattern 0 -> 32 valid pixels 1..32, o_eol on 8,16,24,32,
//    exactly 2 invalid cycles between lines, o_sof on 1st, o_eof on 32nd.
//  2 Continuous i_enable -> second frame o_sof exactly 5 cycles after first frame o_eof; ramp restarts at 1.
//  3 i_ready low for 3 cycles on pixel 5 -> o_pixel=5, o_col=4 held 4 cycles, next pixel 6, no loss.
//  4 i_enable dropped at pixel 10 -> frame finishes through pixel 32, o_busy falls, no further valid.
//  5 Pattern 3, i_const=0xA5, changed to 0x00 mid-frame -> all 32 pixels 0xA5; next frame 0x00.
//  6 rst_n low at pixel 12 -> all outputs 0 asynchronously; after release with i_enable=1, restart at o_sof, pixel 1.

Source files
------------

// File: rtl/pixel_stream_source.sv
// Raster pixel source for the gaussian filter stage: emits IMAGE_WIDTH x IMAGE_HEIGHT
// frames with horizontal/vertical blanking, selectable test patterns, valid/ready
// backpressure and sof/eol/eof markers. Every output is a flop.
//
// state   | meaning
// IDLE    | no frame in progress, waiting for i_enable
// ACTIVE  | presenting pixels of the current line
// HBLANK  | idle cycles after a line
// VBLANK  | extra idle cycles after the last line of a frame
module pixel_stream_source #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int H_BLANK      = 16,
  parameter int V_BLANK      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_enable,
  input  logic [1:0]                      i_pattern,
  input  logic [DATA_WIDTH-1:0]           i_const,
  input  logic                            i_ready,
  output logic [DATA_WIDTH-1:0]           o_pixel,
  output logic                            o_pixel_valid,
  output logic                            o_sof,
  output logic                            o_eol,
  output logic                            o_eof,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  o_col,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] o_row,
  output logic                            o_busy
);

  localparam int COL_W  = $clog2(IMAGE_WIDTH);
  localparam int ROW_W  = $clog2(IMAGE_HEIGHT);
  localparam int B_MAX  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BLK_W  = $clog2(B_MAX + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [BLK_W-1:0] H_LOAD   = BLK_W'(H_BLANK - 1);
  localparam logic [BLK_W-1:0] V_LOAD   = BLK_W'(V_BLANK - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_VBLANK = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [BLK_W-1:0]      blank_cnt, blank_cnt_nxt;
  logic [DATA_WIDTH-1:0] ramp, ramp_nxt;
  logic [1:0]            pat_q, pat_nxt;
  logic [DATA_WIDTH-1:0] const_q, const_nxt;
  logic [COL_W-1:0]      col_nxt;
  logic [ROW_W-1:0]      row_nxt;
  logic                  valid_nxt;
  logic                  load;
  logic                  frame_start;
  logic                  eol_nxt;
  logic                  chk_bit;
  logic [DATA_WIDTH-1:0] pix_nxt;

  // Next-state, next-position and next-pixel computation.
  // The blanking counter counts down to zero; the terminal count ends the blank period.
  always_comb begin
    state_nxt     = state;
    blank_cnt_nxt = blank_cnt;
    col_nxt       = o_col;
    row_nxt       = o_row;
    ramp_nxt      = ramp;
    pat_nxt       = pat_q;
    const_nxt     = const_q;
    valid_nxt     = o_pixel_valid;
    load          = 1'b0;
    frame_start   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_enable) frame_start = 1'b1;
      end
      ST_ACTIVE: begin
        if (i_ready) begin
          if (o_col == COL_LAST) begin
            state_nxt     = ST_HBLANK;
            blank_cnt_nxt = H_LOAD;
            valid_nxt     = 1'b0;
          end else begin
            col_nxt  = o_col + 1'b1;
            ramp_nxt = ramp + 1'b1;
            load     = 1'b1;
          end
        end
      end
      ST_HBLANK: begin
        if (blank_cnt == '0) begin
          // Row counter still holds the line just finished, so it tells us
          // whether this was the last line of the frame.
          if (o_row == ROW_LAST) begin
            state_nxt     = ST_VBLANK;
            blank_cnt_nxt = V_LOAD;
          end else begin
            state_nxt = ST_ACTIVE;
            col_nxt   = '0;
            row_nxt   = o_row + 1'b1;
            ramp_nxt  = ramp + 1'b1;
            load      = 1'b1;
            valid_nxt = 1'b1;
          end
        end else begin
          blank_cnt_nxt = blank_cnt - 1'b1;
        end
      end
      ST_VBLANK: begin
        if (blank_cnt == '0) begin
          if (i_enable) frame_start = 1'b1;
          else          state_nxt   = ST_IDLE;
        end else begin
          blank_cnt_nxt = blank_cnt - 1'b1;
        end
      end
    endcase

    // Pattern and constant are captured only here and held for the whole frame.
    if (frame_start) begin
      state_nxt = ST_ACTIVE;
      col_nxt   = '0;
      row_nxt   = '0;
      ramp_nxt  = DATA_WIDTH'(1);
      pat_nxt   = i_pattern;
      const_nxt = i_const;
      load      = 1'b1;
      valid_nxt = 1'b1;
    end

    eol_nxt = (col_nxt == COL_LAST);
    // Bit 3 of column/row, zero when the counter is narrower than four bits.
    chk_bit = |(((32'(col_nxt) ^ 32'(row_nxt)) >> 3) & 32'd1);

    case (pat_nxt)
      2'd0:    pix_nxt = ramp_nxt;
      2'd1:    pix_nxt = DATA_WIDTH'(col_nxt);
      2'd2:    pix_nxt = {DATA_WIDTH{chk_bit}};
      default: pix_nxt = const_nxt;
    endcase
  end

  // State, counters and registered outputs; data/markers hold while stalled and clear in blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      blank_cnt     <= '0;
      ramp          <= '0;
      pat_q         <= '0;
      const_q       <= '0;
      o_col         <= '0;
      o_row         <= '0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_sof         <= 1'b0;
      o_eol         <= 1'b0;
      o_eof         <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_nxt;
      blank_cnt     <= blank_cnt_nxt;
      ramp          <= ramp_nxt;
      pat_q         <= pat_nxt;
      const_q       <= const_nxt;
      o_col         <= col_nxt;
      o_row         <= row_nxt;
      o_pixel_valid <= valid_nxt;
      o_busy        <= (state_nxt != ST_IDLE);
      if (load) begin
        o_pixel <= pix_nxt;
        o_sof   <= frame_start;
        o_eol   <= eol_nxt;
        o_eof   <= eol_nxt && (row_nxt == ROW_LAST);
      end else if (!valid_nxt) begin
        o_pixel <= '0;
        o_sof   <= 1'b0;
        o_eol   <= 1'b0;
        o_eof   <= 1'b0;
      end
    end
  end

endmodule
